// File: rtl/jt1942_rom_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM read port between NREQ fetch units.
// Optional macro JT1942_ARB_PRIO0_EN gives requester 0 (CPU) absolute priority.
module jt1942_rom_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 17,
    parameter int DW   = 16,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]   ok,
    output logic [DW-1:0]     data_out,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   win;
    logic [AW-1:0]   win_addr;
    logic [NREQ-1:0] gnt_onehot;

    // Scan starts just after the previous winner so every requester gets a turn.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] l);
        logic [IW-1:0] w;
        logic          found;
        int            j;
        w     = l;
        found = 1'b0;
`ifdef JT1942_ARB_PRIO0_EN
        if (r[0]) begin
            w     = '0;
            found = 1'b1;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(l) + k) % NREQ;
            if (!found && r[j]) begin
                w     = IW'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        win = pick(req, last);
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) win_addr = addr[i*AW +: AW];
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IW'(i)) gnt_onehot[i] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ok       <= '0;
            data_out <= '0;
            rom_addr <= '0;
            cnt      <= '0;
            gnt      <= '0;
            last     <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (!downloading && |req) begin
                        rom_addr <= win_addr;
                        gnt      <= win;
                        cnt      <= 3'(LAT);
                        state    <= WAIT;
`ifdef JT1942_ARB_PRIO0_EN
                        // CPU grants do not disturb the rotation among the others.
                        if (!req[0]) last <= win;
`else
                        last <= win;
`endif
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        data_out <= rom_data;
                        ok       <= gnt_onehot;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    ok    <= '0;
                    state <= IDLE;
                end
                default: begin
                    ok    <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt1942_rom_arbiter.sv
// Randomised bench for jt1942_rom_arbiter: transaction-level arbitration model feeds a
// scoreboard queue that an independent monitor drains on every ok pulse.
module tb_jt1942_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 17;
    localparam int DW   = 16;
    localparam int LAT  = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              downloading = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ-1:0]   ok;
    logic [DW-1:0]     data_out;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              busy;

    jt1942_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .req(req), .addr(addr),
        .ok(ok), .data_out(data_out), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
        return a[15:0] ^ {a[16], a[16:2]} ^ 16'h5A3C;
    endfunction

    // ROM with LAT clocks of registered latency
    logic [DW-1:0] rpipe [LAT];
    always @(posedge clk) begin
        rpipe[0] <= romf(rom_addr);
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign rom_data = rpipe[LAT-1];

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model state
    int last_m, next_free, busy_until, inflight;
    logic [AW-1:0]   exp_rom_addr;
    logic [NREQ-1:0] pend;
    int p_raise, p_drop, p_dl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic int model_pick();
`ifdef JT1942_ARB_PRIO0_EN
        if (req[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        last_m       = NREQ - 1;
        next_free    = 0;
        busy_until   = -1;
        inflight     = -1;
        exp_rom_addr = '0;
    endtask

    // One clock of the model: judge the edge just taken, then drive the next inputs.
    task automatic step();
        int w;
        logic [AW-1:0] a;
        cyc++;
        if (cyc >= next_free && !downloading && |req) begin
            w = model_pick();
            a = addr[w*AW +: AW];
            q.push_back('{id: w, data: romf(a), due: cyc + LAT + 1});
            exp_rom_addr = a;
            next_free    = cyc + LAT + 3;
            busy_until   = cyc + LAT + 1;
            inflight     = w;
`ifdef JT1942_ARB_PRIO0_EN
            if (w != 0) last_m = w;
`else
            last_m = w;
`endif
        end
        chk("busy", 64'(busy), 64'(cyc <= busy_until));
        chk("rom_addr", 64'(rom_addr), 64'(exp_rom_addr));
        for (int i = 0; i < NREQ; i++) begin
            if (ok[i]) begin
                req[i]  = 1'b0;
                pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(99) < p_raise) begin
                req[i]  = 1'b1;
                pend[i] = 1'b1;
            end else if (req[i] && inflight == i && cyc < busy_until && $urandom_range(99) < p_drop) begin
                req[i] = 1'b0;
            end
            if ($urandom_range(99) < 30) addr[i*AW +: AW] = AW'($urandom);
        end
        if ($urandom_range(99) < p_dl) downloading = ~downloading;
    endtask

    task automatic run_phase(input int n, input int pr, input int pd, input int pl);
        p_raise = pr;
        p_drop  = pd;
        p_dl    = pl;
        repeat (n) begin
            @(posedge clk);
            #1;
            step();
        end
    endtask

    task automatic mid_reset();
        int guard;
        guard = 0;
        while (!(cyc < busy_until) && guard < 50) begin
            @(posedge clk);
            #1;
            step();
            guard++;
        end
        chk("reset_hit_inflight", 64'(cyc < busy_until), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ok", 64'(ok), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
        chk("midrst_data", 64'(data_out), 64'd0);
        model_reset();
        req         = '0;
        pend        = '0;
        downloading = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: runs after the driver in each cycle, pops on every ok pulse
    initial begin
        logic [NREQ-1:0] eo;
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (|ok) begin
                    if (q.size() == 0) begin
                        chk("ok_unexpected", 64'(ok), 64'd0);
                    end else begin
                        e  = q.pop_front();
                        eo = '0;
                        eo[e.id] = 1'b1;
                        chk("ok_id", 64'(ok), 64'(eo));
                        chk("data_out", 64'(data_out), 64'(e.data));
                        chk("ok_cycle", 64'(cyc), 64'(e.due));
                    end
                end else if (q.size() > 0 && cyc >= q[0].due) begin
                    e = q.pop_front();
                    chk("ok_missing", 64'(ok), 64'(1 << e.id));
                end
            end
        end
    end

    initial begin
        model_reset();
        pend        = '1;
        req         = '1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ok", 64'(ok), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // all requesters re-raise immediately: strict rotation, one access per LAT+3 clocks
        run_phase(16 * (LAT + 3) + 4, 100, 0, 0);
        run_phase(300, 50, 20, 5);
        mid_reset();
        run_phase(300, 40, 10, 15);
        mid_reset();
        run_phase(200, 70, 0, 2);
        downloading = 1'b0;
        run_phase(40, 0, 0, 0);
        chk("drain_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
